// File: rtl/ocs_slot_scheduler.sv
// Slot-timing sequencer for the OCS controller: waits for stable ToR links, pulses sim-start,
// then cycles SLOT -> CONFIG -> SYNC, steering the crossbars via slot_id and handshaking time sync.
module ocs_slot_scheduler #(
   parameter int          P_CHANNEL_NUM   = 8,
   parameter logic [31:0] P_SLOT_LEN      = 32'h0000_0927,
   parameter logic [31:0] P_CONFIG_DELAY  = 32'h0000_00EA,
   parameter logic [15:0] P_STABLE_CYCLES = 16'd1024,
   parameter logic [15:0] P_SYNC_TIMEOUT  = 16'd512
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [P_CHANNEL_NUM-1:0] i_link_up,
   output logic                     o_sim_start,
   output logic [P_CHANNEL_NUM-1:0] o_sync_req,
   input  logic [P_CHANNEL_NUM-1:0] i_sync_ack,
   output logic                     o_slot_id,
   output logic                     o_slot_active,
   output logic                     o_cfg_busy,
   output logic [15:0]              o_slot_cnt,
   output logic                     o_sync_err
);

   // state  | meaning
   // IDLE   | waiting for all links to be stable
   // START  | one-cycle sim-start, initial sync request issued
   // SLOT   | slot in progress, crossbar configuration fixed
   // CONFIG | crossbar reconfiguring to the toggled slot_id
   // SYNC   | waiting for every channel's sync ack or timeout
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_SLOT   = 3'd2;
   localparam logic [2:0] ST_CONFIG = 3'd3;
   localparam logic [2:0] ST_SYNC   = 3'd4;

   // Zero-length settings behave as a single cycle.
   localparam logic [31:0] SLOT_LAST   = (P_SLOT_LEN == 32'd0) ? 32'd0 : P_SLOT_LEN - 32'd1;
   localparam logic [31:0] CFG_LAST    = (P_CONFIG_DELAY == 32'd0) ? 32'd0 : P_CONFIG_DELAY - 32'd1;
   localparam logic [31:0] TMO_LAST    = {16'd0, (P_SYNC_TIMEOUT == 16'd0) ? 16'd0 : P_SYNC_TIMEOUT - 16'd1};
   localparam logic [15:0] STABLE_LAST = (P_STABLE_CYCLES == 16'd0) ? 16'd0 : P_STABLE_CYCLES - 16'd1;

   logic [2:0]               state_q,    state_d;
   logic [31:0]              cnt_q,      cnt_d;
   logic [15:0]              stable_q,   stable_d;
   logic [P_CHANNEL_NUM-1:0] sync_req_q, sync_req_d;
   logic                     slot_id_q,  slot_id_d;
   logic [15:0]              slot_cnt_q, slot_cnt_d;
   logic                     sync_timeout;
   logic                     links_ok;
   logic [P_CHANNEL_NUM-1:0] req_left;

   assign links_ok = &i_link_up;
   assign req_left = sync_req_q & ~i_sync_ack;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q + 32'd1;
      stable_d     = stable_q;
      sync_req_d   = sync_req_q;
      slot_id_d    = slot_id_q;
      slot_cnt_d   = slot_cnt_q;
      sync_timeout = 1'b0;

      case (state_q)
         ST_IDLE: begin
            sync_req_d = '0;
            if (!links_ok) begin
               stable_d = 16'd0;
            end else if (stable_q == STABLE_LAST) begin
               stable_d   = 16'd0;
               sync_req_d = '1;
               state_d    = ST_START;
            end else begin
               stable_d = stable_q + 16'd1;
            end
         end
         ST_START: begin
            sync_req_d = req_left;
            state_d    = ST_SLOT;
         end
         ST_SLOT: begin
            sync_req_d = req_left;
            if (cnt_q == SLOT_LAST) begin
               // Initial-sync requests still outstanding are dropped silently here.
               sync_req_d = '0;
               slot_id_d  = ~slot_id_q;
               slot_cnt_d = slot_cnt_q + 16'd1;
               state_d    = ST_CONFIG;
            end
         end
         ST_CONFIG: begin
            if (cnt_q == CFG_LAST) begin
               sync_req_d = '1;
               state_d    = ST_SYNC;
            end
         end
         ST_SYNC: begin
            sync_req_d = req_left;
            // Completion is checked first so a last ack coinciding with expiry is a success.
            if (req_left == '0) begin
               state_d = ST_SLOT;
            end else if (cnt_q == TMO_LAST) begin
               sync_timeout = 1'b1;
               sync_req_d   = '0;
               state_d      = ST_SLOT;
            end
         end
         default: begin
            sync_req_d = '0;
            state_d    = ST_IDLE;
         end
      endcase

      // Link loss overrides every timer expiry and ack decided above.
      if (state_q != ST_IDLE && !links_ok) begin
         state_d      = ST_IDLE;
         sync_req_d   = '0;
         slot_id_d    = 1'b0;
         slot_cnt_d   = slot_cnt_q;
         stable_d     = 16'd0;
         sync_timeout = 1'b0;
      end

      if (state_d != state_q) begin
         cnt_d = 32'd0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 32'd0;
         stable_q   <= 16'd0;
         sync_req_q <= '0;
         slot_id_q  <= 1'b0;
         slot_cnt_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         stable_q   <= stable_d;
         sync_req_q <= sync_req_d;
         slot_id_q  <= slot_id_d;
         slot_cnt_q <= slot_cnt_d;
      end
   end

   assign o_sim_start   = (state_q == ST_START);
   assign o_slot_active = (state_q == ST_SLOT);
   assign o_cfg_busy    = (state_q == ST_CONFIG);
   assign o_sync_req    = sync_req_q;
   assign o_slot_id     = slot_id_q;
   assign o_slot_cnt    = slot_cnt_q;
   assign o_sync_err    = sync_timeout;

endmodule

// File: tb/tb_ocs_slot_scheduler.sv
// Directed-plus-random bench for ocs_slot_scheduler; expected outputs come from per-phase
// arithmetic on the ack schedule (ack cycle per channel), not from a copy of the FSM.
module tb_ocs_slot_scheduler;

   logic        clk;
   logic        rst_a, rst_b;
   logic [7:0]  link;
   logic [7:0]  ack;

   logic        a_start, a_id, a_act, a_busy, a_err;
   logic [7:0]  a_req;
   logic [15:0] a_cnt;
   logic        b_start, b_id, b_act, b_busy, b_err;
   logic [7:0]  b_req;
   logic [15:0] b_cnt;

   int          checks;
   int          errors;
   logic        sel;
   int          tmo;
   logic        exp_id;
   logic [15:0] exp_cnt;
   // Per channel: cycle index (within the current phase) at which the ack is driven;
   // the request bit is expected high while that index is >= the current cycle.
   int          ack_at[8];

   ocs_slot_scheduler #(
      .P_CHANNEL_NUM(8), .P_SLOT_LEN(32'd20), .P_CONFIG_DELAY(32'd5),
      .P_STABLE_CYCLES(16'd16), .P_SYNC_TIMEOUT(16'd8)
   ) dut_a (
      .i_clk(clk), .i_rst(rst_a), .i_link_up(link), .o_sim_start(a_start),
      .o_sync_req(a_req), .i_sync_ack(ack), .o_slot_id(a_id), .o_slot_active(a_act),
      .o_cfg_busy(a_busy), .o_slot_cnt(a_cnt), .o_sync_err(a_err)
   );

   ocs_slot_scheduler #(
      .P_CHANNEL_NUM(8), .P_SLOT_LEN(32'd20), .P_CONFIG_DELAY(32'd5),
      .P_STABLE_CYCLES(16'd16), .P_SYNC_TIMEOUT(16'd16)
   ) dut_b (
      .i_clk(clk), .i_rst(rst_b), .i_link_up(link), .o_sim_start(b_start),
      .o_sync_req(b_req), .i_sync_ack(ack), .o_slot_id(b_id), .o_slot_active(b_act),
      .o_cfg_busy(b_busy), .o_slot_cnt(b_cnt), .o_sync_err(b_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [28:0] obs();
      if (sel == 1'b0) return {a_start, a_req, a_id, a_act, a_busy, a_err, a_cnt};
      return {b_start, b_req, b_id, b_act, b_busy, b_err, b_cnt};
   endfunction

   function automatic logic [28:0] pk(input logic st, input logic [7:0] rq, input logic id,
                                      input logic act, input logic busy, input logic err,
                                      input logic [15:0] cnt);
      return {st, rq, id, act, busy, err, cnt};
   endfunction

   function automatic logic [7:0] exp_req(input int k);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = (ack_at[i] >= k);
      return r;
   endfunction

   task automatic check(input string tag, input logic [28:0] expv);
      logic [28:0] o;
      #1;
      o = obs();
      checks++;
      assert (o === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h (start,req,id,act,busy,err,cnt)", tag, o, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive_ack(input int k);
      for (int i = 0; i < 8; i++)
         ack[i] = (k == ack_at[i]) || (k > ack_at[i] && ($urandom_range(0, 1) == 1));
   endtask

   task automatic clear_sched();
      for (int i = 0; i < 8; i++) ack_at[i] = -2;
   endtask

   task automatic init_sync_random();
      for (int i = 0; i < 8; i++) ack_at[i] = int'($urandom_range(0, 25)) - 1;
   endtask

   task automatic do_start();
      for (int c = 0; c < 16; c++) begin
         ack = 8'($urandom);
         check("idle", pk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, exp_cnt));
         tick();
      end
      drive_ack(-1);
      check("start", pk(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, exp_cnt));
      tick();
      exp_id = 1'b0;
   endtask

   task automatic do_slot(input int flap_at);
      for (int k = 0; k < 20; k++) begin
         if (k == flap_at) link[4] = 1'b0;
         drive_ack(k);
         check("slot", pk(1'b0, exp_req(k), exp_id, 1'b1, 1'b0, 1'b0, exp_cnt));
         tick();
         if (k == flap_at) begin
            link   = 8'hFF;
            exp_id = 1'b0;
            clear_sched();
            return;
         end
      end
      exp_cnt = exp_cnt + 16'd1;
      exp_id  = ~exp_id;
      clear_sched();
   endtask

   task automatic do_config();
      for (int k = 0; k < 5; k++) begin
         drive_ack(k);
         check("config", pk(1'b0, 8'h00, exp_id, 1'b0, 1'b1, 1'b0, exp_cnt));
         tick();
      end
   endtask

   task automatic do_sync(input int rst_at);
      int dmax;
      int last;
      dmax = 0;
      for (int i = 0; i < 8; i++) if (ack_at[i] > dmax) dmax = ack_at[i];
      last = (dmax <= tmo - 1) ? dmax : tmo - 1;
      for (int k = 0; k <= last; k++) begin
         drive_ack(k);
         check("sync", pk(1'b0, exp_req(k), exp_id, 1'b0, 1'b0,
                          (dmax > tmo - 1) && (k == tmo - 1), exp_cnt));
         if (k == rst_at) begin
            rst_a = 1'b1;
            check("async_rst", 29'd0);
            clear_sched();
            return;
         end
         tick();
      end
      clear_sched();
   endtask

   task automatic period_random(input int maxd);
      do_slot(-1);
      do_config();
      for (int i = 0; i < 8; i++) ack_at[i] = int'($urandom_range(0, maxd));
      do_sync(-1);
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst_a   = 1'b1;
      rst_b   = 1'b1;
      link    = 8'hFF;
      ack     = 8'h00;
      sel     = 1'b0;
      tmo     = 8;
      exp_id  = 1'b0;
      exp_cnt = 16'd0;
      clear_sched();

      #3;
      check("reset_a", 29'd0);
      sel = 1'b1;
      check("reset_b", 29'd0);
      sel = 1'b0;

      tick();
      rst_a = 1'b0;
      init_sync_random();
      do_start();
      do_slot(-1);
      do_config();
      for (int i = 0; i < 8; i++) ack_at[i] = 3;
      do_sync(-1);

      // Last ack lands exactly on the timeout cycle: success, no error.
      do_slot(-1);
      do_config();
      for (int i = 0; i < 8; i++) ack_at[i] = int'($urandom_range(0, 6));
      ack_at[$urandom_range(0, 7)] = 7;
      do_sync(-1);

      // Channel 2 never acks.
      do_slot(-1);
      do_config();
      for (int i = 0; i < 8; i++) ack_at[i] = int'($urandom_range(0, 5));
      ack_at[2] = 1000;
      do_sync(-1);

      repeat (6) period_random(10);

      do_slot(-1);
      do_config();
      for (int i = 0; i < 8; i++) ack_at[i] = int'($urandom_range(0, 4));
      do_sync(-1);
      do_slot(7);
      init_sync_random();
      do_start();
      do_slot(-1);
      do_config();

      for (int i = 0; i < 4; i++) ack_at[i] = 6;
      for (int i = 4; i < 8; i++) ack_at[i] = 0;
      do_sync(2);
      tick();
      check("rst_hold", 29'd0);
      tick();
      rst_a   = 1'b0;
      exp_cnt = 16'd0;
      exp_id  = 1'b0;
      init_sync_random();
      do_start();
      period_random(4);
      do_slot(-1);

      rst_a   = 1'b1;
      sel     = 1'b1;
      tmo     = 16;
      rst_b   = 1'b0;
      exp_cnt = 16'd0;
      exp_id  = 1'b0;
      init_sync_random();
      do_start();
      do_slot(-1);
      do_config();
      for (int i = 0; i < 7; i++) ack_at[i] = 2;
      ack_at[7] = 12;
      do_sync(-1);
      repeat (3) period_random(20);
      do_slot(-1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ocs_slot_scheduler.md
Name: ocs_slot_scheduler

Overview:
Slot-timing sequencer inside the OCS controller. Waits until all P_CHANNEL_NUM ToR control links are stable, then issues a one-shot simulation-start. After that it repeats a fixed cycle: slot, OCS reconfiguration, time sync. It drives the slot_id that steers the OCS0/OCS1 crossbars and handshakes a time-sync request with every channel's control-frame generator.

Parameters:
P_CHANNEL_NUM, 8, number of ToR control channels
P_SLOT_LEN, 32'h0000_0927, slot duration in i_clk cycles (2343)
P_CONFIG_DELAY, 32'h0000_00EA, OCS reconfiguration time in i_clk cycles (234)
P_STABLE_CYCLES, 16'd1024, consecutive all-links-up cycles required before start
P_SYNC_TIMEOUT, 16'd512, maximum cycles to wait for all sync acks

Ports:
i_clk  in  1  controller user clock
i_rst  in  1  asynchronous active-high reset
i_link_up  in  P_CHANNEL_NUM  per-channel GT/link-ready (already synchronous to i_clk)
o_sim_start  out  1  one-cycle pulse; servers begin traffic
o_sync_req  out  P_CHANNEL_NUM  per-channel time-sync request, level
i_sync_ack  in  P_CHANNEL_NUM  per-channel one-cycle ack: sync frame sent
o_slot_id  out  1  current OCS configuration; drives the OCS modules
o_slot_active  out  1  high while in SLOT state
o_cfg_busy  out  1  high while in CONFIG state
o_slot_cnt  out  16  completed-slot counter, wraps 16'hFFFF -> 0
o_sync_err  out  1  one-cycle pulse on sync timeout

Behaviour:
- One clock, i_clk. Reset is asynchronous and active-high on i_rst.
- Reset values: all outputs 0; state IDLE; all counters 0.
- FSM states: IDLE, START, SLOT, CONFIG, SYNC.
- IDLE: the stable counter increments while &i_link_up and clears on any 0. When it reaches P_STABLE_CYCLES-1 with links still up, go to START.
- START (1 cycle): o_sim_start=1, o_sync_req=all ones, then go to SLOT. This initial sync runs concurrently with slot 0, and its acks are collected as in SYNC.
- SLOT: o_slot_active=1 for exactly P_SLOT_LEN cycles, using a 32-bit counter from 0 to P_SLOT_LEN-1. On the last cycle go to CONFIG and increment o_slot_cnt.
- CONFIG: o_slot_id toggles on the entry cycle, i.e. the first CONFIG cycle shows the new value. o_cfg_busy=1 for exactly P_CONFIG_DELAY cycles, then go to SYNC.
- SYNC: on entry, o_sync_req = all ones. A bit clears on the cycle after its i_sync_ack is sampled high.
  - When all bits are clear, go to SLOT next cycle. A new slot starts 1 cycle after the last ack.
  - If the timeout counter reaches P_SYNC_TIMEOUT-1 first: o_sync_err pulses, o_sync_req clears, go to SLOT.
- Handshake rules:
  - i_sync_ack on a channel whose o_sync_req bit is 0 is ignored.
  - A START-issued request still pending when SLOT ends is cleared on CONFIG entry. This case does not raise o_sync_err.
- Zero-valued P_SLOT_LEN or P_CONFIG_DELAY is treated as 1. P_SYNC_TIMEOUT=0 is treated as 1.
- Link loss: any i_link_up bit low in START, SLOT, CONFIG or SYNC forces IDLE on the next cycle.
  - o_sync_req, o_slot_active and o_cfg_busy clear.
  - o_slot_id returns to 0; o_slot_cnt holds.
  - No o_sim_start is issued until links have been re-stable for P_STABLE_CYCLES. The restart pulses o_sim_start again.
- Simultaneous events:
  - Link loss has priority over every timer expiry and ack.
  - The last ack and the timeout in the same cycle count as success: no o_sync_err.
- Reset mid-operation returns immediately to reset values; no pulses are generated.

Test Plan:
- Basic start: P_STABLE_CYCLES=16, all links up from cycle 0 after reset -> o_sim_start pulses exactly once at cycle 16 and o_sync_req=8'hFF; o_slot_id=0.
- Slot/config timing: P_SLOT_LEN=20, P_CONFIG_DELAY=5, all channels ack 3 cycles into SYNC.
  - o_slot_active high for exactly 20 cycles; o_cfg_busy for exactly 5.
  - o_slot_id toggles 0->1->0 over successive CONFIG entries; o_slot_cnt increments 1, 2, 3.
- Staggered acks: channel 7 acks 10 cycles after channels 0-6 -> o_sync_req=8'h80 for those 10 cycles. SLOT starts 1 cycle after channel 7's ack.
- Timeout: channel 2 never acks, P_SYNC_TIMEOUT=8 -> o_sync_err pulses once on the 8th SYNC cycle, o_sync_req goes 0, next state SLOT.
- Link flap: drop i_link_up[4] for 1 cycle mid-SLOT.
  - Next cycle: state IDLE, o_slot_id=0, outputs cleared, o_slot_cnt held.
  - o_sim_start re-pulses 16 cycles after links are all up again.
- Async reset: assert i_rst during SYNC with o_sync_req=8'h0F -> all outputs 0 in the same cycle without a clock edge. After release, the start sequence repeats from IDLE.
